// File: rtl/gray_seq_gen_if.sv
// gray_seq_gen_if: run-control and Gray-word valid/ready bundle for gray_seq_gen.
// Revision: 1.0
`default_nettype none

interface gray_seq_gen_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             up;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH:0]   num_words;
  logic [WIDTH-1:0] gray_out;
  logic             gray_valid;
  logic             gray_ready;
  logic             busy;
  logic             done;
  logic             wrap;

  // Generator side.
  modport master (
    input  start, up, load_val, num_words, gray_ready,
    output gray_out, gray_valid, busy, done, wrap
  );

  // Controller and consumer side.
  modport slave (
    output start, up, load_val, num_words, gray_ready,
    input  gray_out, gray_valid, busy, done, wrap
  );
endinterface

`default_nettype wire

// File: rtl/gray_seq_gen.sv
// gray_seq_gen: emits a programmable-length up/down run of Gray codes over valid/ready.
// Revision: 1.0
`default_nettype none

module gray_seq_gen #(
  parameter int WIDTH = 4
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  gray_seq_gen_if.master   bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH:0]   REM_ONE = (WIDTH+1)'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bin_cnt_q, bin_cnt_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH:0]   remaining_q, remaining_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic             xfer;

  assign xfer = (state_q == S_RUN) && bus.gray_ready;

  always_comb begin
    state_d     = state_q;
    bin_cnt_d   = bin_cnt_q;
    remaining_d = remaining_q;
    dir_d       = dir_q;
    wrap_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          bin_cnt_d   = bus.load_val;
          remaining_d = bus.num_words;
          dir_d       = bus.up;
          state_d     = (bus.num_words != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (xfer) begin
          remaining_d = remaining_q - REM_ONE;
          bin_cnt_d   = dir_q ? (bin_cnt_q + WIDTH'(1)) : (bin_cnt_q - WIDTH'(1));
          wrap_d      = dir_q ? (bin_cnt_q == CNT_MAX) : (bin_cnt_q == '0);
          if (remaining_q == REM_ONE) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // gray_out always tracks the count that will be held after this edge.
    gray_d = bin_cnt_d ^ (bin_cnt_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bin_cnt_q   <= '0;
      gray_q      <= '0;
      remaining_q <= '0;
      dir_q       <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_cnt_q   <= bin_cnt_d;
      gray_q      <= gray_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
      wrap_q      <= wrap_d;
    end
  end

  assign bus.gray_out   = gray_q;
  assign bus.gray_valid = (state_q == S_RUN);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.wrap       = wrap_q;
endmodule

`default_nettype wire

// File: tb/tb_gray_seq_gen.sv
// tb_gray_seq_gen: scoreboard bench for gray_seq_gen (WIDTH=4).
// Revision: 1.0
`default_nettype none

module tb_gray_seq_gen;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_pop = 0;
  int   n_done = 0;
  int   n_wrap = 0;
  logic [WIDTH-1:0] sb[$];

  gray_seq_gen_if #(.WIDTH(WIDTH)) bus_if ();

  gray_seq_gen #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on each transfer and checks stall stability.
  initial begin
    logic             prev_stall;
    logic [WIDTH-1:0] prev_gray;
    logic [WIDTH-1:0] exp_w;
    prev_stall = 1'b0;
    prev_gray  = '0;
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        check_val("stall_valid", 32'(bus_if.gray_valid), 32'd1);
        check_val("stall_hold", 32'(bus_if.gray_out), 32'(prev_gray));
      end
      if (bus_if.gray_valid && bus_if.gray_ready) begin
        check_val("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_w = sb.pop_front();
          check_val("gray_word", 32'(bus_if.gray_out), 32'(exp_w));
        end
        n_pop++;
      end
      if (bus_if.done) n_done++;
      if (bus_if.wrap) n_wrap++;
      prev_stall = bus_if.gray_valid && !bus_if.gray_ready;
      prev_gray  = bus_if.gray_out;
    end
  end

  task automatic run_seq(input logic [WIDTH-1:0] lv, input logic [WIDTH:0] nw,
                         input logic dir, input int stall, input bit midstart);
    logic [WIDTH-1:0] b;
    int  exp_wraps;
    logic last_wrap, seen_done, wrap_at_done;
    int  d0, w0, p0;
    b = lv;
    exp_wraps = 0;
    last_wrap = 1'b0;
    seen_done = 1'b0;
    wrap_at_done = 1'b0;
    d0 = n_done; w0 = n_wrap; p0 = n_pop;
    for (int i = 0; i < int'(nw); i++) begin
      sb.push_back(b ^ (b >> 1));
      last_wrap = dir ? (b == '1) : (b == '0);
      if (last_wrap) exp_wraps++;
      b = dir ? b + 1'b1 : b - 1'b1;
    end
    bus_if.start      = 1'b1;
    bus_if.up         = dir;
    bus_if.load_val   = lv;
    bus_if.num_words  = nw;
    bus_if.gray_ready = (stall == 0);
    tick();
    bus_if.start     = 1'b0;
    bus_if.up        = 1'($urandom);
    bus_if.load_val  = WIDTH'($urandom);
    bus_if.num_words = (WIDTH+1)'($urandom);
    @(negedge clk);
    check_val("lat_valid", 32'(bus_if.gray_valid), 32'(nw != 0));
    check_val("lat_busy", 32'(bus_if.busy), 32'd1);
    check_val("lat_done", 32'(bus_if.done), 32'(nw == 0));
    if (bus_if.done) begin
      seen_done = 1'b1;
      wrap_at_done = bus_if.wrap;
    end
    if (stall > 0) begin
      repeat (stall) tick();
      bus_if.gray_ready = 1'b1;
    end
    if (midstart) begin
      tick();
      bus_if.start     = 1'b1;
      bus_if.load_val  = 4'd9;
      bus_if.num_words = 5'd2;
      bus_if.up        = ~dir;
      tick();
      tick();
      bus_if.start = 1'b0;
    end
    for (int c = 0; c < 200 && !seen_done; c++) begin
      @(negedge clk);
      if (bus_if.done) begin
        seen_done = 1'b1;
        wrap_at_done = bus_if.wrap;
        check_val("done_novalid", 32'(bus_if.gray_valid), 32'd0);
      end
    end
    check_val("done_seen", 32'(seen_done), 32'd1);
    check_val("done_wrap", 32'(wrap_at_done), 32'((nw != 0) && last_wrap));
    @(negedge clk);
    check_val("busy_fall", 32'(bus_if.busy), 32'd0);
    check_val("done_pulse", 32'(bus_if.done), 32'd0);
    #1;
    check_val("words", 32'(n_pop - p0), 32'(nw));
    check_val("sb_drained", 32'(sb.size()), 32'd0);
    check_val("done_cnt", 32'(n_done - d0), 32'd1);
    check_val("wrap_cnt", 32'(n_wrap - w0), 32'(exp_wraps));
    tick();
  endtask

  initial begin
    int d0, w0;
    bus_if.start      = 1'b0;
    bus_if.up         = 1'b1;
    bus_if.load_val   = '0;
    bus_if.num_words  = '0;
    bus_if.gray_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check_val("rst_valid", 32'(bus_if.gray_valid), 32'd0);
    check_val("rst_busy", 32'(bus_if.busy), 32'd0);
    check_val("rst_gray", 32'(bus_if.gray_out), 32'd0);
    check_val("rst_done", 32'(bus_if.done), 32'd0);
    check_val("rst_wrap", 32'(bus_if.wrap), 32'd0);
    rst_n = 1'b1;
    tick();

    run_seq(4'd0, 5'd16, 1'b1, 0, 1'b0);
    run_seq(4'd0, 5'd3,  1'b0, 0, 1'b0);
    run_seq(4'd5, 5'd4,  1'b1, 3, 1'b0);
    run_seq(4'd0, 5'd0,  1'b1, 0, 1'b0);
    run_seq(4'd2, 5'd10, 1'b1, 0, 1'b1);
    run_seq(4'd14, 5'd20, 1'b1, 0, 1'b0);
    run_seq(4'd1, 5'd31, 1'b0, 1, 1'b0);

    // start held through the DONE cycle must not launch a second run.
    d0 = n_done;
    bus_if.start     = 1'b1;
    bus_if.num_words = 5'd0;
    tick();
    tick();
    bus_if.start = 1'b0;
    @(negedge clk);
    check_val("start_in_done_busy", 32'(bus_if.busy), 32'd0);
    check_val("start_in_done_cnt", 32'(n_done - d0), 32'd1);
    tick();

    // Reset mid-run after five words of a sixteen-word run.
    w0 = n_wrap;
    d0 = n_done;
    for (int i = 0; i < 5; i++) sb.push_back(4'(i ^ (i >> 1)));
    bus_if.start     = 1'b1;
    bus_if.up        = 1'b1;
    bus_if.load_val  = 4'd0;
    bus_if.num_words = 5'd16;
    tick();
    bus_if.start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_val("midrst_valid", 32'(bus_if.gray_valid), 32'd0);
    check_val("midrst_busy", 32'(bus_if.busy), 32'd0);
    check_val("midrst_gray", 32'(bus_if.gray_out), 32'd0);
    check_val("midrst_done", 32'(bus_if.done), 32'd0);
    #1;
    check_val("midrst_sb", 32'(sb.size()), 32'd0);
    check_val("midrst_nodone", 32'(n_done - d0), 32'd0);
    check_val("midrst_nowrap", 32'(n_wrap - w0), 32'd0);
    tick();

    run_seq(4'd0, 5'd3, 1'b1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
